// File: rtl/rgf_writeback.sv
// rtl/rgf_writeback.sv - register file write-port arbiter with load response queue and pending-load scoreboard
// Optional macro RGF_WB_WAW_CHECK_EN adds the sticky waw_err output.
module rgf_writeback #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    input  logic                          ld_issue,
    input  logic [4:0]                    ld_issue_rd,
    output logic                          ld_issue_ready,
    input  logic                          ld_resp_valid,
    input  logic [4:0]                    ld_resp_rd,
    input  logic [XLEN-1:0]               ld_resp_data,
    output logic                          ld_resp_ready,
    output logic                          rgf_we,
    output logic [4:0]                    rgf_wn,
    output logic [XLEN-1:0]               rgf_data,
    output logic [31:0]                   busy,
    output logic [$clog2(LQ_DEPTH):0]     lq_count
`ifdef RGF_WB_WAW_CHECK_EN
    ,
    output logic                          waw_err
`endif
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] LQ_FULL = CW'(LQ_DEPTH);

    logic [4:0]      lq_rd_q   [LQ_DEPTH];
    logic [4:0]      lq_rd_d   [LQ_DEPTH];
    logic [XLEN-1:0] lq_data_q [LQ_DEPTH];
    logic [XLEN-1:0] lq_data_d [LQ_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   lq_count_q, lq_count_d;
    logic [31:0]     busy_q, busy_d;
    logic            rgf_we_q, rgf_we_d;
    logic [4:0]      rgf_wn_q, rgf_wn_d;
    logic [XLEN-1:0] rgf_data_q, rgf_data_d;

    logic push;
    logic pop;
    logic [4:0] head_rd;

    // Readiness uses the registered count so a same-cycle pop never admits an extra entry.
    assign ld_resp_ready  = !rst && (lq_count_q < LQ_FULL);
    assign ld_issue_ready = (ld_issue_rd == 5'd0) || !busy_q[ld_issue_rd];
    assign push           = ld_resp_valid && ld_resp_ready;
    assign pop            = !alu_valid && (lq_count_q != '0);
    assign head_rd        = lq_rd_q[rd_ptr_q];

    always_comb begin
        lq_rd_d    = lq_rd_q;
        lq_data_d  = lq_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lq_count_d = lq_count_q;
        busy_d     = busy_q;
        rgf_we_d   = 1'b0;
        rgf_wn_d   = rgf_wn_q;
        rgf_data_d = rgf_data_q;

        if (push) begin
            lq_rd_d[wr_ptr_q]   = ld_resp_rd;
            lq_data_d[wr_ptr_q] = ld_resp_data;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end

        if (alu_valid) begin
            rgf_we_d   = (alu_rd != 5'd0);
            rgf_wn_d   = alu_rd;
            rgf_data_d = alu_data;
        end else if (pop) begin
            rgf_we_d         = (head_rd != 5'd0);
            rgf_wn_d         = head_rd;
            rgf_data_d       = lq_data_q[rd_ptr_q];
            rd_ptr_d         = rd_ptr_q + PW'(1);
            busy_d[head_rd]  = 1'b0;
        end

        // Applied after the clear so a same-cycle reissue to the popped rd stays busy.
        if (ld_issue && ld_issue_ready && (ld_issue_rd != 5'd0)) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        case ({push, pop})
            2'b10:   lq_count_d = lq_count_q + CW'(1);
            2'b01:   lq_count_d = lq_count_q - CW'(1);
            default: lq_count_d = lq_count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq_rd_q[i]   <= '0;
                lq_data_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lq_count_q <= '0;
            busy_q     <= '0;
            rgf_we_q   <= 1'b0;
            rgf_wn_q   <= '0;
            rgf_data_q <= '0;
        end else begin
            lq_rd_q    <= lq_rd_d;
            lq_data_q  <= lq_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lq_count_q <= lq_count_d;
            busy_q     <= busy_d;
            rgf_we_q   <= rgf_we_d;
            rgf_wn_q   <= rgf_wn_d;
            rgf_data_q <= rgf_data_d;
        end
    end

    assign rgf_we   = rgf_we_q;
    assign rgf_wn   = rgf_wn_q;
    assign rgf_data = rgf_data_q;
    assign busy     = busy_q;
    assign lq_count = lq_count_q;

`ifdef RGF_WB_WAW_CHECK_EN
    logic waw_err_q, waw_err_d;

    // Flags an ALU write racing a pending load, or a response for a load never issued.
    always_comb begin
        waw_err_d = waw_err_q;
        if (alu_valid && (alu_rd != 5'd0) && busy_q[alu_rd]) begin
            waw_err_d = 1'b1;
        end
        if (push && !busy_q[ld_resp_rd]) begin
            waw_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waw_err_q <= 1'b0;
        end else begin
            waw_err_q <= waw_err_d;
        end
    end

    assign waw_err = waw_err_q;
`endif

endmodule
